// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer
//   Receive-data register stage for the UART Rx path. Bytes from the
//   deserialiser are packed into WORD-wide words. Each completed or flushed
//   word goes into a small first-word-fall-through FIFO. The consumer drains
//   the FIFO over a valid/ready handshake. If a word arrives while the FIFO
//   is full, it is dropped and a sticky overrun flag is raised.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   rx_byte        received character
//   rx_byte_valid  single-cycle strobe qualifying rx_byte
//   flush          push the partially assembled word, if any
//   clear_ovf      clear the sticky overrun flag
//   word_out       FIFO head word (0 when empty)
//   word_nbytes    valid bytes in word_out (0 when empty)
//   word_valid     FIFO not empty
//   word_ready     consumer pops the head when word_valid && word_ready
//   byte_cnt       bytes currently held in the assembly register
//   fifo_level     words in the FIFO, 0..FIFO_DEPTH
//   overrun        sticky: a word was dropped
module uart_rx_word_packer #(
  parameter int BYTE_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter bit LSB_FIRST      = 1'b1,
  localparam int WORD = BYTE_WIDTH * BYTES_PER_WORD,
  localparam int NBW  = $clog2(BYTES_PER_WORD + 1),
  localparam int CW   = $clog2(BYTES_PER_WORD),
  localparam int LW   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  input  logic                  rx_byte_valid,
  input  logic                  flush,
  input  logic                  clear_ovf,
  output logic [WORD-1:0]       word_out,
  output logic [NBW-1:0]        word_nbytes,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [CW-1:0]         byte_cnt,
  output logic [LW-1:0]         fifo_level,
  output logic                  overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WORD-1:0]                  asm_q, asm_d, asm_upd;
  logic [CW-1:0]                    cnt_q, cnt_d, slot;
  logic [FIFO_DEPTH-1:0][WORD-1:0]  mem_q;
  logic [FIFO_DEPTH-1:0][NBW-1:0]   nb_q;
  logic [PW-1:0]                    rd_q, wr_q;
  logic [LW-1:0]                    lvl_q, lvl_d;
  logic                             ovf_q, ovf_d;

  logic           last_byte, push_req, push_ok, drop, pop;
  logic [NBW-1:0] push_nb;

  // In MS-first mode the first byte lands in the top slot.
  assign slot = LSB_FIRST ? cnt_q : CW'(BYTES_PER_WORD - 1) - cnt_q;

  always_comb begin
    asm_upd = asm_q;
    for (int s = 0; s < BYTES_PER_WORD; s++)
      if (rx_byte_valid && slot == CW'(s))
        asm_upd[s*BYTE_WIDTH +: BYTE_WIDTH] = rx_byte;
  end

  assign last_byte = rx_byte_valid && (cnt_q == CW'(BYTES_PER_WORD - 1));
  // A byte that arrives with flush is folded into the flushed word, so a
  // single push covers both.
  assign push_req  = last_byte || (flush && (rx_byte_valid || cnt_q != '0));
  assign push_nb   = rx_byte_valid ? NBW'(cnt_q) + NBW'(1) : NBW'(cnt_q);
  assign pop       = (lvl_q != '0) && word_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
  assign push_ok   = push_req && ((lvl_q < LW'(FIFO_DEPTH)) || pop);
  assign drop      = push_req && !push_ok;

  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (push_req) begin
      // The assembly register clears even when the word is dropped.
      asm_d = '0;
      cnt_d = '0;
    end else if (rx_byte_valid) begin
      asm_d = asm_upd;
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign lvl_d = lvl_q + LW'(push_ok) - LW'(pop);
  // If a drop and clear_ovf happen in the same cycle, the flag stays set.
  assign ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q <= '0;
      cnt_q <= '0;
      mem_q <= '0;
      nb_q  <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      if (push_ok) begin
        mem_q[wr_q] <= asm_upd;
        nb_q[wr_q]  <= push_nb;
        wr_q        <= wr_q + PW'(1);  // power-of-2 depth wraps naturally
      end
      if (pop) rd_q <= rd_q + PW'(1);
    end
  end

  // FWFT head straight from registered storage, masked to 0 when empty.
  assign word_valid  = (lvl_q != '0);
  assign word_out    = word_valid ? mem_q[rd_q] : '0;
  assign word_nbytes = word_valid ? nb_q[rd_q]  : '0;
  assign byte_cnt    = cnt_q;
  assign fifo_level  = lvl_q;
  assign overrun     = ovf_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
module tb_uart_rx_word_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rx_byte;
  logic rx_v, fl, clr, rdy;

  logic [31:0] wl, wm;
  logic [2:0]  nl, nm, lvl_l, lvl_m;
  logic        vl, vm, ol, om;
  logic [1:0]  cl, cm;

  always #5 clk = ~clk;

  uart_rx_word_packer #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst_n), .rx_byte(rx_byte), .rx_byte_valid(rx_v),
    .flush(fl), .clear_ovf(clr), .word_out(wl), .word_nbytes(nl),
    .word_valid(vl), .word_ready(rdy), .byte_cnt(cl), .fifo_level(lvl_l),
    .overrun(ol));

  uart_rx_word_packer #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst_n), .rx_byte(rx_byte), .rx_byte_valid(rx_v),
    .flush(fl), .clear_ovf(clr), .word_out(wm), .word_nbytes(nm),
    .word_valid(vm), .word_ready(rdy), .byte_cnt(cm), .fifo_level(lvl_m),
    .overrun(om));

  int checks = 0;
  int failures = 0;

  // Reference model: bytes gathered in a list; a word is built from the list
  // when it is pushed, in both byte orders.
  logic [7:0]  m_asm[$];
  logic [31:0] q_lsb[$], q_msb[$];
  int          q_nb[$];
  bit          m_ovf;

  function automatic logic [31:0] e_wl(); return q_lsb.size() ? q_lsb[0] : 32'h0; endfunction
  function automatic logic [31:0] e_wm(); return q_msb.size() ? q_msb[0] : 32'h0; endfunction
  function automatic int          e_nb(); return q_nb.size() ? q_nb[0] : 0; endfunction

  function automatic void model_reset();
    m_asm.delete(); q_lsb.delete(); q_msb.delete(); q_nb.delete(); m_ovf = 0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] b, bit f, bit c, bit r);
    bit pop, push, drop;
    logic [31:0] a, m;
    int n;
    pop = (q_lsb.size() > 0) && r;
    push = 0; a = 0; m = 0; n = 0;
    if (v) m_asm.push_back(b);
    if (m_asm.size() == 4 || (f && m_asm.size() > 0)) begin
      push = 1;
      n = m_asm.size();
      for (int i = 0; i < n; i++) begin
        a = a | (32'(m_asm[i]) << (8 * i));
        m = m | (32'(m_asm[i]) << (8 * (3 - i)));
      end
      m_asm.delete();
    end
    drop = push && (q_lsb.size() == 4) && !pop;
    if (pop) begin void'(q_lsb.pop_front()); void'(q_msb.pop_front()); void'(q_nb.pop_front()); end
    if (push && !drop) begin q_lsb.push_back(a); q_msb.push_back(m); q_nb.push_back(n); end
    if (drop) m_ovf = 1; else if (c) m_ovf = 0;
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic drive(bit v, logic [7:0] b, bit f, bit c, bit r);
    rx_v = v; rx_byte = b; fl = f; clr = c; rdy = r;
    model_step(v, b, f, c, r);
    @(posedge clk); #1;
    rx_v = 0; rx_byte = 0; fl = 0; clr = 0; rdy = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q_lsb.size() > 0; i++) drive(0, 8'h0, 0, 0, 1);
  endtask

  task automatic test_reset();
    rst_n = 0; rx_v = 0; rx_byte = 0; fl = 0; clr = 0; rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vl !== 1'b0 || wl !== 32'h0 || nl !== 3'd0) begin failures++;
      $display("FAIL reset_out valid=%b word=%h nb=%0d want 0/0/0", vl, wl, nl); end
    checks++; if (lvl_l !== 3'd0 || cl !== 2'd0 || ol !== 1'b0) begin failures++;
      $display("FAIL reset_state lvl=%0d cnt=%0d ovf=%b want 0/0/0", lvl_l, cl, ol); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_lsb_word();
    drive(1, 8'h11, 0, 0, 0); drive(1, 8'h22, 0, 0, 0);
    checks++; if (cl !== 2'd2) begin failures++; $display("FAIL cnt_two got %0d want 2", cl); end
    drive(1, 8'h33, 0, 0, 0); drive(1, 8'h44, 0, 0, 0);
    checks++; if (wl !== 32'h44332211 || nl !== 3'd4 || lvl_l !== 3'd1 || vl !== 1'b1) begin failures++;
      $display("FAIL lsb_word got %h nb=%0d lvl=%0d want 44332211/4/1", wl, nl, lvl_l); end
    checks++; if (wm !== 32'h11223344) begin failures++;
      $display("FAIL msb_of_lsb_seq got %h want 11223344", wm); end
    checks++; if (cl !== 2'd0) begin failures++; $display("FAIL cnt_after_word got %0d want 0", cl); end
    drain();
  endtask

  task automatic test_msb_and_flush();
    drive(1, 8'hAA, 0, 0, 0); drive(1, 8'hBB, 0, 0, 0);
    drive(1, 8'hCC, 0, 0, 0); drive(1, 8'hDD, 0, 0, 0);
    checks++; if (wm !== 32'hAABBCCDD || nm !== 3'd4) begin failures++;
      $display("FAIL msb_word got %h nb=%0d want aabbccdd/4", wm, nm); end
    drain();
    drive(1, 8'h01, 0, 0, 0); drive(1, 8'h02, 0, 0, 0);
    drive(0, 8'h00, 1, 0, 0);
    checks++; if (wm !== 32'h01020000 || nm !== 3'd2) begin failures++;
      $display("FAIL msb_flush got %h nb=%0d want 01020000/2", wm, nm); end
    checks++; if (wl !== 32'h00000201 || nl !== 3'd2) begin failures++;
      $display("FAIL lsb_flush got %h nb=%0d want 00000201/2", wl, nl); end
    drive(0, 8'h00, 1, 0, 0);  // flush with nothing held: no-op
    checks++; if (lvl_l !== 3'd1) begin failures++;
      $display("FAIL empty_flush lvl=%0d want 1", lvl_l); end
    drain();
  endtask

  task automatic test_flush_with_byte();
    drive(1, 8'h11, 0, 0, 0); drive(1, 8'h22, 0, 0, 0);
    drive(1, 8'h55, 1, 0, 0);
    checks++; if (wl !== 32'h00552211 || nl !== 3'd3 || cl !== 2'd0 || lvl_l !== 3'd1) begin failures++;
      $display("FAIL flush_byte got %h nb=%0d cnt=%0d lvl=%0d want 00552211/3/0/1", wl, nl, cl, lvl_l); end
    drain();
  endtask

  task automatic test_overrun();
    logic [31:0] exp[5];
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) drive(1, 8'(w * 16 + b + 1), 0, 0, 0);
      exp[w] = {8'(w*16+4), 8'(w*16+3), 8'(w*16+2), 8'(w*16+1)};
    end
    checks++; if (lvl_l !== 3'd4 || ol !== 1'b1 || om !== 1'b1) begin failures++;
      $display("FAIL ovf_full lvl=%0d ovf=%b/%b want 4/1", lvl_l, ol, om); end
    for (int w = 0; w < 4; w++) begin
      checks++; if (wl !== exp[w]) begin failures++;
        $display("FAIL ovf_order%0d got %h want %h", w, wl, exp[w]); end
      drive(0, 8'h00, 0, 0, 1);
    end
    checks++; if (vl !== 1'b0 || ol !== 1'b1) begin failures++;
      $display("FAIL ovf_drained valid=%b ovf=%b want 0/1", vl, ol); end
    drive(0, 8'h00, 0, 1, 0);
    checks++; if (ol !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", ol); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) drive(1, 8'(i + 8'h80), 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 8'(i + 8'hC0), 0, 0, 0);
    drive(1, 8'hC3, 0, 0, 1);
    checks++; if (lvl_l !== 3'd4 || ol !== 1'b0) begin failures++;
      $display("FAIL push_pop_full lvl=%0d ovf=%b want 4/0", lvl_l, ol); end
    checks++; if (wl !== 32'h87868584) begin failures++;
      $display("FAIL push_pop_head got %h want 87868584", wl); end
    for (int i = 0; i < 3; i++) drive(1, 8'(i + 8'hD0), 0, 0, 0);
    drive(1, 8'hD3, 0, 1, 0);
    checks++; if (ol !== 1'b1 || cl !== 2'd0) begin failures++;
      $display("FAIL set_beats_clear ovf=%b cnt=%0d want 1/0", ol, cl); end
    drain();
    drive(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), $urandom_range(0, 2) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0);
      checks++; if (wl !== e_wl() || nl !== 3'(e_nb()) || wm !== e_wm() || nm !== 3'(e_nb())) begin failures++;
        $display("FAIL rnd_word cyc%0d got %h/%h nb=%0d want %h/%h nb=%0d", i, wl, wm, nl, e_wl(), e_wm(), e_nb()); end
      checks++; if (lvl_l !== 3'(q_lsb.size()) || vl !== (q_lsb.size() > 0) || lvl_m !== lvl_l) begin failures++;
        $display("FAIL rnd_level cyc%0d got %0d want %0d", i, lvl_l, q_lsb.size()); end
      checks++; if (cl !== 2'(m_asm.size()) || cm !== cl || ol !== m_ovf || om !== m_ovf) begin failures++;
        $display("FAIL rnd_state cyc%0d cnt=%0d ovf=%b want %0d/%b", i, cl, ol, m_asm.size(), m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 0; i < 10; i++) drive(1, 8'(i + 1), 0, 0, 0);
    checks++; if (lvl_l !== 3'd2 || cl !== 2'd2) begin failures++;
      $display("FAIL pre_reset lvl=%0d cnt=%0d want 2/2", lvl_l, cl); end
    #2 rst_n = 0; model_reset();
    #1;
    checks++; if (lvl_l !== 3'd0 || cl !== 2'd0 || vl !== 1'b0 || wl !== 32'h0 || wm !== 32'h0) begin failures++;
      $display("FAIL mid_reset lvl=%0d cnt=%0d valid=%b word=%h want 0/0/0/0", lvl_l, cl, vl, wl); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (vl !== 1'b0 || ol !== 1'b0) begin failures++;
      $display("FAIL post_reset valid=%b ovf=%b want 0/0", vl, ol); end
  endtask

  initial begin
    test_reset();
    test_lsb_word();
    test_msb_and_flush();
    test_flush_with_byte();
    test_overrun();
    test_full_push_pop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
